// File: rtl/lemming_arena.sv
// lemming_arena: 1-D track environment for the lemming walker FSM.
// Tracks the lemming position between two walls, reports registered bumps
// when the lemming walks into a blocked cell, counts bumps (saturating) and
// flags illegal simultaneous walk requests.
// Optional programmable obstacle: define LEMMING_ARENA_OBSTACLE_EN to build it.
module lemming_arena #(
    parameter int TRACK_LEN = 16,
    parameter int START_POS = 0,
    localparam int PW = $clog2(TRACK_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          obs_wr,
    input  logic [PW-1:0] obs_pos,
    input  logic          obs_clr,
    output logic          bump_left,
    output logic          bump_right,
    output logic [PW-1:0] pos,
    output logic          obs_active,
    output logic [PW-1:0] obs_cell,
    output logic [7:0]    bump_cnt,
    output logic          dir_err
);
    localparam logic [PW-1:0] LAST_CELL  = PW'(TRACK_LEN - 1);
    localparam logic [PW-1:0] START_CELL = PW'(START_POS);
    localparam logic [PW-1:0] ONE        = PW'(1);

    logic [PW-1:0] pos_q, pos_d;
    logic          bump_l_q, bump_l_d;
    logic          bump_r_q, bump_r_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          dir_err_q, dir_err_d;
    logic          blk_l, blk_r;

    // Obstacle state as seen by the blocking logic (pre-edge values).
    logic          obs_act_w;
    logic [PW-1:0] obs_cell_w;

`ifdef LEMMING_ARENA_OBSTACLE_EN
    logic          obs_act_q, obs_act_d;
    logic [PW-1:0] obs_cell_q, obs_cell_d;
    logic          in_range;
    logic          wr_ok;

    // For power-of-two tracks every encodable cell is on the track.
    if (TRACK_LEN == (1 << PW)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (obs_pos <= LAST_CELL);
    end

    // Obstacle update: an accepted write beats a clear; a rejected write
    // (onto the lemming or off the track) lets the clear through.
    always_comb begin
        obs_act_d  = obs_act_q;
        obs_cell_d = obs_cell_q;
        wr_ok      = obs_wr && in_range && (obs_pos != pos_q);
        if (wr_ok) begin
            obs_act_d  = 1'b1;
            obs_cell_d = obs_pos;
        end else if (obs_clr) begin
            obs_act_d  = 1'b0;
        end
    end

    // Obstacle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            obs_act_q  <= 1'b0;
            obs_cell_q <= '0;
        end else begin
            obs_act_q  <= obs_act_d;
            obs_cell_q <= obs_cell_d;
        end
    end

    assign obs_act_w  = obs_act_q;
    assign obs_cell_w = obs_cell_q;
`else
    // Without the obstacle the programming inputs have no effect.
    logic unused_obs_inputs;
    assign unused_obs_inputs = ^{obs_wr, obs_pos, obs_clr};
    assign obs_act_w  = 1'b0;
    assign obs_cell_w = '0;
`endif

    // Blocking, move decision and saturating bump counter.
    always_comb begin
        pos_d     = pos_q;
        bump_l_d  = 1'b0;
        bump_r_d  = 1'b0;
        dir_err_d = dir_err_q;
        cnt_d     = cnt_q;
        blk_l     = (pos_q == '0) || (obs_act_w && (obs_cell_w == pos_q - ONE));
        blk_r     = (pos_q == LAST_CELL) || (obs_act_w && (obs_cell_w == pos_q + ONE));
        case ({walk_left, walk_right})
            2'b10: begin
                if (blk_l) bump_l_d = 1'b1;
                else       pos_d    = pos_q - ONE;
            end
            2'b01: begin
                if (blk_r) bump_r_d = 1'b1;
                else       pos_d    = pos_q + ONE;
            end
            2'b11:   dir_err_d = 1'b1;
            default: ;
        endcase
        if ((bump_l_d || bump_r_d) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Position, bump, counter and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q     <= START_CELL;
            bump_l_q  <= 1'b0;
            bump_r_q  <= 1'b0;
            cnt_q     <= 8'd0;
            dir_err_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            bump_l_q  <= bump_l_d;
            bump_r_q  <= bump_r_d;
            cnt_q     <= cnt_d;
            dir_err_q <= dir_err_d;
        end
    end

    assign pos        = pos_q;
    assign bump_left  = bump_l_q;
    assign bump_right = bump_r_q;
    assign bump_cnt   = cnt_q;
    assign dir_err    = dir_err_q;
    assign obs_active = obs_act_w;
    assign obs_cell   = obs_cell_w;

endmodule

// File: tb/tb_lemming_arena.sv
// Bench for lemming_arena: a 4-cell arena (START_POS 0) for wall tests and an
// 8-cell arena (START_POS 3) for illegal-direction, reset, obstacle and
// closed-loop walker tests. Both share the same input stimulus.
module tb_lemming_arena;

    // Clock and shared stimulus
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       walk_left = 1'b0;
    logic       walk_right = 1'b0;
    logic       obs_wr = 1'b0;
    logic [2:0] obs_pos = 3'd0;
    logic       obs_clr = 1'b0;

    always #5 clk = ~clk;

    // 4-cell arena outputs
    logic       a_bump_left, a_bump_right, a_obs_active, a_dir_err;
    logic [1:0] a_pos, a_obs_cell;
    logic [7:0] a_bump_cnt;

    // 8-cell arena outputs
    logic       b_bump_left, b_bump_right, b_obs_active, b_dir_err;
    logic [2:0] b_pos, b_obs_cell;
    logic [7:0] b_bump_cnt;

    lemming_arena #(.TRACK_LEN(4), .START_POS(0)) u_arena4 (
        .clk(clk), .reset(reset), .walk_left(walk_left), .walk_right(walk_right),
        .obs_wr(obs_wr), .obs_pos(obs_pos[1:0]), .obs_clr(obs_clr),
        .bump_left(a_bump_left), .bump_right(a_bump_right), .pos(a_pos),
        .obs_active(a_obs_active), .obs_cell(a_obs_cell), .bump_cnt(a_bump_cnt),
        .dir_err(a_dir_err)
    );

    lemming_arena #(.TRACK_LEN(8), .START_POS(3)) u_arena8 (
        .clk(clk), .reset(reset), .walk_left(walk_left), .walk_right(walk_right),
        .obs_wr(obs_wr), .obs_pos(obs_pos), .obs_clr(obs_clr),
        .bump_left(b_bump_left), .bump_right(b_bump_right), .pos(b_pos),
        .obs_active(b_obs_active), .obs_cell(b_obs_cell), .bump_cnt(b_bump_cnt),
        .dir_err(b_dir_err)
    );

    // Scoreboard
    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_q_a[$];   // {pos, bump_left, bump_right, bump_cnt}
    logic [17:0] exp_q_b[$];   // {pos, bl, br, cnt, dir_err, obs_active, obs_cell}

    typedef struct packed {
        logic        rst;
        logic        wl;
        logic        wr;
        logic [11:0] exp;
    } vec_a_t;

    typedef struct packed {
        logic        rst;
        logic        wl;
        logic        wr;
        logic        ow;
        logic [2:0]  op;
        logic        oc;
        logic [17:0] exp;
    } vec_b_t;

    function automatic vec_a_t mk_a(input int rst, wl, wr, p, bl, br, cnt);
        vec_a_t v;
        v.rst = 1'(rst);
        v.wl  = 1'(wl);
        v.wr  = 1'(wr);
        v.exp = {2'(p), 1'(bl), 1'(br), 8'(cnt)};
        return v;
    endfunction

    // obs_cell is only meaningful while an obstacle is active, so it is
    // zeroed on both sides of the compare when obs_active is 0.
    function automatic vec_b_t mk_b(input int rst, wl, wr, ow, op, oc,
                                    p, bl, br, cnt, derr, oa, ocell);
        vec_b_t v;
        v.rst = 1'(rst);
        v.wl  = 1'(wl);
        v.wr  = 1'(wr);
        v.ow  = 1'(ow);
        v.op  = 3'(op);
        v.oc  = 1'(oc);
        v.exp = {3'(p), 1'(bl), 1'(br), 8'(cnt), 1'(derr), 1'(oa), (oa != 0) ? 3'(ocell) : 3'd0};
        return v;
    endfunction

    function automatic logic [11:0] obs_a();
        return {a_pos, a_bump_left, a_bump_right, a_bump_cnt};
    endfunction

    function automatic logic [17:0] obs_b();
        return {b_pos, b_bump_left, b_bump_right, b_bump_cnt, b_dir_err,
                b_obs_active, b_obs_active ? b_obs_cell : 3'd0};
    endfunction

    // Driver tasks: apply one cycle of stimulus, queue its expectation,
    // and return 1 time unit after the active edge.
    task automatic drive_a(input vec_a_t v);
        reset = v.rst; walk_left = v.wl; walk_right = v.wr;
        obs_wr = 1'b0; obs_pos = 3'd0; obs_clr = 1'b0;
        exp_q_a.push_back(v.exp);
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input vec_b_t v);
        reset = v.rst; walk_left = v.wl; walk_right = v.wr;
        obs_wr = v.ow; obs_pos = v.op; obs_clr = v.oc;
        exp_q_b.push_back(v.exp);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [11:0] got_a, exp_a;
        logic [17:0] got_b, exp_b;
        exp_q_a.push_back(12'd0);
        drive_b(mk_b(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        got_a = obs_a(); exp_a = exp_q_a.pop_front();
        vectors++;
        if (got_a !== exp_a) begin
            miscompares++;
            $display("FAIL reset_arena4: got %h expected %h", got_a, exp_a);
        end
        got_b = obs_b(); exp_b = exp_q_b.pop_front();
        vectors++;
        if (got_b !== exp_b) begin
            miscompares++;
            $display("FAIL reset_arena8: got %h expected %h", got_b, exp_b);
        end
    endtask

    task automatic test_wall_bounce();
        vec_a_t v[$];
        logic [11:0] got, exp;
        v.push_back(mk_a(1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_a(0, 0, 1, 1, 0, 0, 0));
        v.push_back(mk_a(0, 0, 1, 2, 0, 0, 0));
        v.push_back(mk_a(0, 0, 1, 3, 0, 0, 0));
        v.push_back(mk_a(0, 0, 1, 3, 0, 1, 1));
        v.push_back(mk_a(0, 0, 0, 3, 0, 0, 1));
        foreach (v[i]) begin
            drive_a(v[i]);
            got = obs_a(); exp = exp_q_a.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wall_bounce[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_left_wall();
        vec_a_t v[$];
        logic [11:0] got, exp;
        v.push_back(mk_a(1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_a(0, 1, 0, 0, 1, 0, 1));
        v.push_back(mk_a(0, 1, 0, 0, 1, 0, 2));
        v.push_back(mk_a(0, 1, 0, 0, 1, 0, 3));
        v.push_back(mk_a(0, 0, 1, 1, 0, 0, 3));
        foreach (v[i]) begin
            drive_a(v[i]);
            got = obs_a(); exp = exp_q_a.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL left_wall[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_illegal_and_reset();
        vec_b_t v[$];
        logic [17:0] got, exp;
        v.push_back(mk_b(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 1, 1, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0));
        v.push_back(mk_b(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 7, 0, 1, 1, 1, 0, 0));
        v.push_back(mk_b(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_b(v[i]);
            got = obs_b(); exp = exp_q_b.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL illegal_reset[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

`ifdef LEMMING_ARENA_OBSTACLE_EN
    task automatic test_obstacle();
        vec_b_t v[$];
        logic [17:0] got, exp;
        v.push_back(mk_b(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 0, 1, 4, 0, 2, 0, 0, 0, 0, 1, 4));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 4));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 3, 0, 1, 1, 0, 1, 4));
        v.push_back(mk_b(0, 0, 1, 0, 0, 1, 3, 0, 1, 2, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 4, 0, 0, 2, 0, 0, 0));
        v.push_back(mk_b(0, 0, 0, 1, 4, 0, 4, 0, 0, 2, 0, 0, 0));
        v.push_back(mk_b(0, 0, 0, 1, 5, 1, 4, 0, 0, 2, 0, 1, 5));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 4, 0, 1, 3, 0, 1, 5));
        v.push_back(mk_b(0, 0, 0, 1, 3, 0, 4, 0, 0, 3, 0, 1, 3));
        v.push_back(mk_b(0, 1, 0, 0, 0, 0, 4, 1, 0, 4, 0, 1, 3));
        v.push_back(mk_b(0, 1, 0, 1, 4, 1, 4, 1, 0, 5, 0, 0, 0));
        v.push_back(mk_b(0, 1, 0, 0, 0, 0, 3, 0, 0, 5, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 1, 4, 0, 4, 0, 0, 5, 0, 1, 4));
        foreach (v[i]) begin
            drive_b(v[i]);
            got = obs_b(); exp = exp_q_b.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL obstacle[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask
`else
    task automatic test_obstacle_disabled();
        vec_b_t v[$];
        logic [17:0] got, exp;
        v.push_back(mk_b(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 0, 1, 4, 0, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0));
        v.push_back(mk_b(0, 0, 1, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0));
        foreach (v[i]) begin
            drive_b(v[i]);
            got = obs_b(); exp = exp_q_b.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL obstacle_disabled[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask
`endif

    // Moore walker closing the loop on the 8-cell arena; a wall-only track
    // model supplies the expected position, bumps and counter every cycle.
    task automatic test_closed_loop();
        int   m_pos, m_cnt, bursts;
        logic m_bl, m_br, dir, nd, last_side, prev_any, side;
        logic [17:0] got, exp;
        reset = 1'b1; walk_left = 1'b0; walk_right = 1'b0;
        obs_wr = 1'b0; obs_clr = 1'b0; obs_pos = 3'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pos = 3; m_cnt = 0; m_bl = 1'b0; m_br = 1'b0; dir = 1'b0;
        bursts = 0; last_side = 1'b0; prev_any = 1'b0;
        for (int c = 0; c < 1400; c++) begin
            nd = m_bl ? 1'b1 : (m_br ? 1'b0 : dir);
            if (!dir) begin
                m_br = 1'b0;
                if (m_pos == 0) m_bl = 1'b1;
                else begin m_pos = m_pos - 1; m_bl = 1'b0; end
            end else begin
                m_bl = 1'b0;
                if (m_pos == 7) m_br = 1'b1;
                else begin m_pos = m_pos + 1; m_br = 1'b0; end
            end
            if ((m_bl || m_br) && m_cnt < 255) m_cnt = m_cnt + 1;
            exp_q_b.push_back({3'(m_pos), m_bl, m_br, 8'(m_cnt), 1'b0, 1'b0, 3'd0});
            walk_left = !dir; walk_right = dir;
            @(posedge clk); #1;
            dir = nd;
            got = obs_b(); exp = exp_q_b.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL closed_loop[%0d]: got %h expected %h", c, got, exp);
            end
            if ((b_bump_left || b_bump_right) && !prev_any) begin
                side = b_bump_right;
                if (bursts > 0) begin
                    vectors++;
                    if (side !== !last_side) begin
                        miscompares++;
                        $display("FAIL closed_loop_alternate[%0d]: got side %0d expected %0d", c, side, !last_side);
                    end
                end
                last_side = side;
                bursts++;
            end
            prev_any = b_bump_left || b_bump_right;
        end
        walk_left = 1'b0; walk_right = 1'b0;
        vectors++;
        if (b_bump_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL closed_loop_saturate: got %0d expected 255", b_bump_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_wall_bounce();
        test_left_wall();
        test_illegal_and_reset();
`ifdef LEMMING_ARENA_OBSTACLE_EN
        test_obstacle();
`else
        test_obstacle_disabled();
`endif
        test_closed_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
